// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// The VERIFY state exists only when PROG_LOADER_READBACK_EN is defined.
package prog_loader_pkg;

  localparam int DEF_IMEM_WORDS = 128;
  localparam int DEF_RUN_W      = 16;
  localparam int WORD_STRIDE    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
`ifdef PROG_LOADER_READBACK_EN
    ST_VERIFY = 3'd2,
`endif
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic [63:0] word_addr(input logic [31:0] idx);
    return {32'd0, idx} * 64'(WORD_STRIDE);
  endfunction

endpackage

// File: rtl/prog_loader_cycle_counter.sv
// Run-cycle down-counter: load a start value, decrement to zero, flag zero.
module loader_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, then enables the CPU for a fixed budget.
// Optional readback check of the loaded image: define PROG_LOADER_READBACK_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting stream beats, one external write per beat
// VERIFY | reading the image back and comparing with the shadow copy
// RUN    | cpu_enable high while the run counter drains
// DONE   | sequence complete, done held until the next start
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_WORDS = DEF_IMEM_WORDS,
  parameter int RUN_W      = DEF_RUN_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(IMEM_WORDS):0]   n_words,
  input  logic [RUN_W-1:0]              run_cycles,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [31:0]                   s_data,
  output logic [63:0]                   addr_ext,
  output logic                          wen_ext,
  output logic                          ren_ext,
  output logic [31:0]                   wdata_ext,
  input  logic [31:0]                   rdata_ext,
  output logic                          cpu_enable,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int NW_W  = $clog2(IMEM_WORDS) + 1;
  localparam int IDX_W = $clog2(IMEM_WORDS);

  state_e            state_q;
  logic              s_ready_q, wen_q, cpu_en_q, busy_q, done_q, err_q;
  logic              last_q, run_zero_q;
  logic [63:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [NW_W-1:0]   idx_q, n_q;

  logic              start_ok, len_bad, beat;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [RUN_W-1:0]  cnt_init;

  assign len_bad  = (n_words == '0) || (n_words > NW_W'(IMEM_WORDS));
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign beat     = (state_q == ST_LOAD) && !last_q && s_valid && s_ready_q;

  // Counter is primed at start so RUN lasts exactly run_cycles cycles.
  assign cnt_load = start_ok && !len_bad;
  assign cnt_init = run_cycles - RUN_W'(1);
  assign cnt_dec  = (state_q == ST_RUN) && !cnt_zero;

  loader_cycle_counter #(.W(RUN_W)) u_run_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_init),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifdef PROG_LOADER_READBACK_EN
  logic              ren_q, chk_q, mismatch;
  logic [NW_W-1:0]   rd_idx_q, chk_idx_q;
  logic [31:0]       shadow_q [IMEM_WORDS];

  always_ff @(posedge clk) begin
    if (beat) begin
      shadow_q[idx_q[IDX_W-1:0]] <= s_data;
    end
  end

  assign mismatch = chk_q && (rdata_ext != shadow_q[chk_idx_q[IDX_W-1:0]]);
  assign ren_ext  = ren_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata_ext;
  assign ren_ext      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_ready_q  <= 1'b0;
      wen_q      <= 1'b0;
      cpu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      run_zero_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      n_q        <= '0;
`ifdef PROG_LOADER_READBACK_EN
      ren_q      <= 1'b0;
      chk_q      <= 1'b0;
      rd_idx_q   <= '0;
      chk_idx_q  <= '0;
`endif
    end else begin
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PROG_LOADER_READBACK_EN
      ren_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok && len_bad) begin
            err_q   <= 1'b1;
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (start_ok) begin
            state_q    <= ST_LOAD;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            s_ready_q  <= 1'b1;
            idx_q      <= '0;
            last_q     <= 1'b0;
            n_q        <= n_words;
            run_zero_q <= (run_cycles == '0);
          end
        end

        ST_LOAD: begin
          if (last_q) begin
            // The final beat's write is on the bus this cycle; move on after it.
            last_q <= 1'b0;
`ifdef PROG_LOADER_READBACK_EN
            state_q  <= ST_VERIFY;
            ren_q    <= 1'b1;
            addr_q   <= '0;
            rd_idx_q <= '0;
            chk_q    <= 1'b0;
`else
            if (run_zero_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ST_RUN;
              cpu_en_q <= 1'b1;
            end
`endif
          end else if (beat) begin
            wen_q   <= 1'b1;
            addr_q  <= word_addr(32'(idx_q));
            wdata_q <= s_data;
            idx_q   <= idx_q + NW_W'(1);
            if (idx_q == n_q - NW_W'(1)) begin
              s_ready_q <= 1'b0;
              last_q    <= 1'b1;
            end
          end
        end

`ifdef PROG_LOADER_READBACK_EN
        ST_VERIFY: begin
          chk_q     <= ren_q;
          chk_idx_q <= rd_idx_q;
          if (mismatch) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            chk_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (ren_q && ((rd_idx_q + NW_W'(1)) < n_q)) begin
            ren_q    <= 1'b1;
            rd_idx_q <= rd_idx_q + NW_W'(1);
            addr_q   <= word_addr(32'(rd_idx_q) + 32'd1);
          end else if (chk_q && !ren_q) begin
            chk_q <= 1'b0;
            if (run_zero_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ST_RUN;
              cpu_en_q <= 1'b1;
            end
          end
        end
`endif

        ST_RUN: begin
          if (cnt_zero) begin
            state_q  <= ST_DONE;
            cpu_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign wen_ext    = wen_q;
  assign addr_ext   = addr_q;
  assign wdata_ext  = wdata_q;
  assign cpu_enable = cpu_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: write scoreboard, run-length and status checks.
module tb_prog_loader;

  localparam int IMEM  = 128;
  localparam int RUN_W = 16;
`ifdef PROG_LOADER_READBACK_EN
  localparam int READBACK = 1;
`else
  localparam int READBACK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  n_words = '0;
  logic [15:0] run_cycles = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [63:0] addr_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext = '0;
  logic        cpu_enable, busy, done, err;

  prog_loader #(.IMEM_WORDS(IMEM), .RUN_W(RUN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_words(n_words), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t exp_e;

  logic [31:0] words [8];
  logic [31:0] mem [IMEM];
  logic        corrupt = 1'b0;

  int cyc = 0;
  int wr_cnt = 0;
  int cpu_cnt = 0;
  int err_cnt = 0;
  int first_cpu_cyc = -1;
  int last_wen_cyc = -1;
  logic cpu_prev = 1'b0;

  // Instruction-memory model; optionally flips bit 0 of word 1 on readback.
  always @(posedge clk) begin
    if (wen_ext) mem[addr_ext[8:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= mem[addr_ext[8:2]] ^
                 (((corrupt == 1'b1) && (addr_ext[8:2] == 7'd1)) ? 32'h1 : 32'h0);
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cpu_enable) begin
      cpu_cnt = cpu_cnt + 1;
      if (!cpu_prev && first_cpu_cyc < 0) first_cpu_cyc = cyc;
    end
    cpu_prev = cpu_enable;
    if (err) err_cnt = err_cnt + 1;
    if (wen_ext) begin
      wr_cnt = wr_cnt + 1;
      last_wen_cyc = cyc;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write addr=%h data=%h (no write expected)", addr_ext, wdata_ext);
      end else begin
        exp_e = exp_q.pop_front();
        if (addr_ext !== exp_e.a || wdata_ext !== exp_e.d) begin
          errors = errors + 1;
          $display("FAIL write_beat got addr=%h data=%h expected addr=%h data=%h",
                   addr_ext, wdata_ext, exp_e.a, exp_e.d);
        end
      end
    end
    if (!rst) begin
      checks = checks + 1;
      if ((wen_ext && ren_ext) || ((wen_ext || ren_ext) && cpu_enable) ||
          (!wen_ext && !ren_ext && (addr_ext != 64'd0 || wdata_ext != 32'd0))) begin
        errors = errors + 1;
        $display("FAIL bus_invariant wen=%b ren=%b cpu=%b addr=%h wdata=%h expected exclusive strobes and idle bus 0",
                 wen_ext, ren_ext, cpu_enable, addr_ext, wdata_ext);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_cnt = 0;
    cpu_cnt = 0;
    err_cnt = 0;
    first_cpu_cyc = -1;
    last_wen_cyc = -1;
  endtask

  task automatic push_wr(input int k, input logic [31:0] d);
    exp_q.push_back('{a: 64'(k) * 64'd4, d: d});
  endtask

  task automatic do_start(input logic [7:0] n, input logic [15:0] r);
    start = 1'b1;
    n_words = n;
    run_cycles = r;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [31:0] vpat, output bit ok);
    int k = 0;
    int c = 0;
    bit hs;
    while (k < n && c < 300) begin
      s_valid = (c < 32) ? vpat[c] : 1'b1;
      s_data  = s_valid ? words[k] : 32'h0;
      @(negedge clk);
      hs = s_valid && s_ready;
      tick();
      if (hs) k++;
      c++;
    end
    s_valid = 1'b0;
    s_data = 32'h0;
    ok = (k == n);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (!ok && i < bound) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      i++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    n_words = 8'd2;
    run_cycles = 16'd3;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({s_ready, wen_ext, ren_ext, cpu_enable, busy, done, err} !== 7'b0 ||
        addr_ext !== 64'd0 || wdata_ext !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b wen=%b ren=%b cpu=%b busy=%b done=%b err=%b addr=%h expected all 0",
               s_ready, wen_ext, ren_ext, cpu_enable, busy, done, err, addr_ext);
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start got busy=%b s_ready=%b expected 0 0", busy, s_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    words[0] = 32'h00000013;
    words[1] = 32'h00100093;
    words[2] = 32'h00208113;
    clear_stats();
    for (int k = 0; k < 3; k++) push_wr(k, words[k]);
    do_start(8'd3, 16'd5);
    stream(3, 32'hFFFFFFFF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_stream got timeout expected 3 beats"); end
    wait_done(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done got done=0 expected 1 within 60 cycles"); end
    checks++;
    if (cpu_cnt != 5) begin errors++; $display("FAIL basic_run_len got %0d expected 5", cpu_cnt); end
    checks++;
    if (wr_cnt != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_writes got %0d pending %0d expected 3 pending 0", wr_cnt, exp_q.size());
    end
    checks++;
    if (first_cpu_cyc - last_wen_cyc != (READBACK ? 5 : 1)) begin
      errors++;
      $display("FAIL basic_run_gap got %0d expected %0d", first_cpu_cyc - last_wen_cyc, READBACK ? 5 : 1);
    end
    checks++;
    if (busy !== 1'b0 || err_cnt != 0) begin
      errors++;
      $display("FAIL basic_status got busy=%b errs=%0d expected 0 0", busy, err_cnt);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b expected 1", done); end
  endtask

  task automatic test_bad_len();
    logic [7:0] n;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? 8'd0 : 8'(IMEM + 1);
      clear_stats();
      do_start(n, 16'd5);
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_len_err n=%0d got err=%b busy=%b expected 1 0", n, err, busy);
      end
      tick();
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL bad_len_idle n=%0d got err=%b rdy=%b busy=%b done=%b expected 0 0 0 0",
                 n, err, s_ready, busy, done);
      end
      tick();
      checks++;
      if (wr_cnt != 0 || err_cnt != 1) begin
        errors++;
        $display("FAIL bad_len_pulse n=%0d got writes=%0d err_cycles=%0d expected 0 1", n, wr_cnt, err_cnt);
      end
    end
  endtask

  task automatic test_gaps();
    bit ok;
    words[0] = 32'hA0000001;
    words[1] = 32'hA0000002;
    clear_stats();
    push_wr(0, words[0]);
    push_wr(1, words[1]);
    do_start(8'd2, 16'd1);
    stream(2, 32'h00000009, ok);
    wait_done(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL gaps_done got done=0 expected 1"); end
    checks++;
    if (wr_cnt != 2 || exp_q.size() != 0 || cpu_cnt != 1) begin
      errors++;
      $display("FAIL gaps_counts got writes=%0d pending=%0d run=%0d expected 2 0 1",
               wr_cnt, exp_q.size(), cpu_cnt);
    end
  endtask

  task automatic test_reset_run();
    bit ok;
    int i = 0;
    words[0] = 32'hDEADBEEF;
    clear_stats();
    push_wr(0, words[0]);
    do_start(8'd1, 16'd10);
    stream(1, 32'hFFFFFFFF, ok);
    @(negedge clk);
    while (!cpu_enable && i < 30) begin @(negedge clk); i++; end
    checks++;
    if (!cpu_enable) begin errors++; $display("FAIL rst_run_enter got cpu=0 expected 1"); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_abort got cpu=%b done=%b busy=%b expected 0 0 0", cpu_enable, done, busy);
    end
    for (int j = 0; j < 15; j++) tick();
    @(negedge clk);
    checks++;
    if (cpu_cnt != 3 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_after got run=%0d done=%b expected 3 0", cpu_cnt, done);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    clear_stats();
    push_wr(0, words[0]);
    push_wr(1, words[1]);
    do_start(8'd2, 16'd2);
    start = 1'b1;
    n_words = 8'd5;
    run_cycles = 16'd9;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_status got busy=%b rdy=%b done=%b expected 1 1 0", busy, s_ready, done);
    end
    tick();
    start = 1'b0;
    stream(2, 32'hFFFFFFFF, ok);
    wait_done(40, ok);
    checks++;
    if (!ok || wr_cnt != 2 || cpu_cnt != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_ignored got done=%b writes=%0d run=%0d expected 1 2 2", ok, wr_cnt, cpu_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    words[0] = 32'h33333333;
    clear_stats();
    push_wr(0, words[0]);
    do_start(8'd1, 16'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done got done=%b busy=%b expected 0 1", done, busy);
    end
    stream(1, 32'hFFFFFFFF, ok);
    wait_done(20, ok);
    checks++;
    if (!ok || cpu_cnt != 0 || wr_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_run got done=%b run=%0d writes=%0d expected 1 0 1", ok, cpu_cnt, wr_cnt);
    end
  endtask

`ifdef PROG_LOADER_READBACK_EN
  task automatic test_readback_corrupt();
    bit ok;
    int i = 0;
    words[0] = 32'h0000A001;
    words[1] = 32'h0000A002;
    words[2] = 32'h0000A003;
    corrupt = 1'b1;
    clear_stats();
    for (int k = 0; k < 3; k++) push_wr(k, words[k]);
    do_start(8'd3, 16'd5);
    stream(3, 32'hFFFFFFFF, ok);
    @(negedge clk);
    while (!err && i < 20) begin @(negedge clk); i++; end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL verify_err got err=0 expected 1"); end
    for (int j = 0; j < 10; j++) tick();
    checks++;
    if (cpu_cnt != 0 || err_cnt != 1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL verify_abort got run=%0d err_cycles=%0d busy=%b done=%b expected 0 1 0 0",
               cpu_cnt, err_cnt, busy, done);
    end
    corrupt = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_gaps();
    test_reset_run();
    test_start_ignored();
    test_back_to_back();
`ifdef PROG_LOADER_READBACK_EN
    test_readback_corrupt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
